accum_sequencer: RTL and testbench

Control unit that sequences the lab-3 multi-cycle adder datapath as a switch-driven accumulator. It synchronizes and edge-detects the `Run_Accumulate` button and issues exactly one add of `SW` into the accumulator per press, with a start/done handshake to the adder. It queues at most one press that arrives while an add is in flight and guards the handshake with a timeout. It sits between the board I/O (`SW`, buttons) and the adder core; its `Acc` output feeds the LED/HEX display logic.

---
 rtl/accum_pkg.sv | 10 +
 rtl/btn_sync_edge.sv | 26 ++
 rtl/accum_sequencer.sv | 106 ++++++++++
 tb/tb_accum_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// Shared types and default sizing for the switch-driven accumulator sequencer.
package accum_pkg;

  typedef enum logic [1:0] {IDLE, START, WAIT, WRITE} seq_state_t;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_SW_WIDTH = 10;
  localparam int DEF_TIMEOUT  = 64;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous button, followed by a rising-edge detector.
module btn_sync_edge (
  input  logic Clk,
  input  logic Reset_Clear,
  input  logic d,
  output logic pulse
);

  logic r1, r2, r3;

  // NOTE: sequential state uses non-blocking assignments so the r1->r2->r3 chain shifts by exactly one stage per edge.
  always_ff @(posedge Clk or posedge Reset_Clear) begin
    if (Reset_Clear) begin
      r1 <= 1'b0;
      r2 <= 1'b0;
      r3 <= 1'b0;
    end else begin
      r1 <= d;
      r2 <= r1;
      r3 <= r2;
    end
  end

  assign pulse = r2 & ~r3;

endmodule

// File: rtl/accum_sequencer.sv
// Sequences a start/done multi-cycle adder so each button press adds SW into Acc once,
// with a one-deep press queue, sticky overflow/error flags and a WAIT timeout.
module accum_sequencer
  import accum_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int SW_WIDTH = DEF_SW_WIDTH,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                Clk,
  input  logic                Reset_Clear,
  input  logic                Run_Accumulate,
  input  logic [SW_WIDTH-1:0] SW,
  output logic                add_start,
  output logic [WIDTH-1:0]    add_a,
  output logic [WIDTH-1:0]    add_b,
  input  logic                add_done,
  input  logic [WIDTH-1:0]    add_sum,
  input  logic                add_cout,
  output logic [WIDTH-1:0]    Acc,
  output logic                busy,
  output logic                ovf,
  output logic                err,
  output logic [7:0]          acc_count
);

  localparam int              CW      = $clog2(TIMEOUT);
  localparam logic [CW-1:0]   TO_LAST = CW'(TIMEOUT - 1);

  seq_state_t       state;
  logic             run_pulse;
  logic             pending;
  logic [CW-1:0]    tmo;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  btn_sync_edge u_btn (
    .Clk         (Clk),
    .Reset_Clear (Reset_Clear),
    .d           (Run_Accumulate),
    .pulse       (run_pulse)
  );

  // Operand A is the live accumulator; it only changes when leaving WRITE.
  assign add_a = Acc;

  always_ff @(posedge Clk or posedge Reset_Clear) begin
    if (Reset_Clear) begin
      state     <= IDLE;
      pending   <= 1'b0;
      tmo       <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      add_start <= 1'b0;
      add_b     <= '0;
      Acc       <= '0;
      busy      <= 1'b0;
      ovf       <= 1'b0;
      err       <= 1'b0;
      acc_count <= '0;
    end else begin
      // NOTE: add_start defaults low every cycle so it can only ever be a single-cycle pulse.
      add_start <= 1'b0;
      case (state)
        IDLE: begin
          if (run_pulse || pending) begin
            add_b     <= WIDTH'(SW);
            pending   <= 1'b0;
            add_start <= 1'b1;
            busy      <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          if (run_pulse) pending <= 1'b1;
          tmo   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (run_pulse) pending <= 1'b1;
          if (add_done) begin
            sum_q  <= add_sum;
            cout_q <= add_cout;
            state  <= WRITE;
          end else if (tmo == TO_LAST) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        WRITE: begin
          if (run_pulse) pending <= 1'b1;
          Acc       <= sum_q;
          ovf       <= ovf | cout_q;
          acc_count <= acc_count + 8'd1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_sequencer.sv
// Scoreboard bench for accum_sequencer: a behavioural accumulator model predicts each
// completed add, a monitor compares whenever acc_count advances.
module tb_accum_sequencer;

  localparam int W    = 16;
  localparam int SWW  = 10;
  localparam int TO   = 8;
  localparam int MASK = (1 << W) - 1;

  logic           Clk = 1'b0;
  logic           Reset_Clear = 1'b1;
  logic           Run_Accumulate = 1'b0;
  logic [SWW-1:0] SW = '0;
  logic           add_start, add_done, add_cout;
  logic [W-1:0]   add_a, add_b, add_sum, Acc;
  logic           busy, ovf, err;
  logic [7:0]     acc_count;

  accum_sequencer #(.WIDTH(W), .SW_WIDTH(SWW), .TIMEOUT(TO)) dut (
    .Clk            (Clk),
    .Reset_Clear    (Reset_Clear),
    .Run_Accumulate (Run_Accumulate),
    .SW             (SW),
    .add_start      (add_start),
    .add_a          (add_a),
    .add_b          (add_b),
    .add_done       (add_done),
    .add_sum        (add_sum),
    .add_cout       (add_cout),
    .Acc            (Acc),
    .busy           (busy),
    .ovf            (ovf),
    .err            (err),
    .acc_count      (acc_count)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [W-1:0] acc;
    logic [7:0]   cnt;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_starts = 0;
  int   m_acc = 0;
  int   m_cnt = 0;
  bit   m_ovf = 1'b0;
  bit   adder_en  = 1'b1;
  int   adder_lat = 3;
  int   ad_cnt = 0;
  logic [W:0] ad_res;
  logic [7:0] last_cnt = '0;
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Reference accumulator: at most one add in flight plus one queued press.
  function automatic void model_press(input int sw);
    int   s;
    exp_t e;
    if (sb.size() >= 2) return;
    s = m_acc + sw;
    if (s > MASK) m_ovf = 1'b1;
    m_acc = s & MASK;
    m_cnt = (m_cnt + 1) & 255;
    e.acc = m_acc[W-1:0];
    e.cnt = m_cnt[7:0];
    e.ovf = m_ovf;
    sb.push_back(e);
  endfunction

  // Adder model: done with sum of the operands adder_lat cycles after add_start.
  initial begin
    add_done = 1'b0;
    add_sum  = '0;
    add_cout = 1'b0;
    forever begin
      @(negedge Clk);
      add_done = 1'b0;
      if (ad_cnt > 0) begin
        ad_cnt--;
        if (ad_cnt == 0) begin
          add_done = 1'b1;
          {add_cout, add_sum} = ad_res;
        end
      end
      if (add_start === 1'b1 && adder_en) begin
        ad_cnt = adder_lat;
        ad_res = {1'b0, add_a} + {1'b0, add_b};
      end
    end
  end

  // Monitor: every advance of acc_count is one completed add.
  initial begin
    forever begin
      @(negedge Clk);
      if (add_start === 1'b1) n_starts++;
      if (Reset_Clear) begin
        last_cnt = '0;
      end else if (acc_count !== last_cnt) begin
        if (sb.size() == 0) begin
          check("unexpected_write", {24'b0, acc_count}, {24'b0, last_cnt});
        end else begin
          mon_e = sb.pop_front();
          check("sb_acc", {16'b0, Acc}, {16'b0, mon_e.acc});
          check("sb_count", {24'b0, acc_count}, {24'b0, mon_e.cnt});
          check("sb_ovf", {31'b0, ovf}, {31'b0, mon_e.ovf});
        end
        last_cnt = acc_count;
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic press(input logic [SWW-1:0] sw, input int hi);
    @(negedge Clk);
    SW = sw;
    Run_Accumulate = 1'b1;
    repeat (hi) @(negedge Clk);
    Run_Accumulate = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    do begin
      @(negedge Clk);
      k++;
    end while ((busy === 1'b1 || sb.size() != 0) && k < budget);
    check("idle_reached", {31'b0, (busy === 1'b1) || (sb.size() != 0)}, 32'd0);
  endtask

  task automatic wait_start(input int budget);
    int k = 0;
    do begin
      @(negedge Clk);
      k++;
    end while (add_start !== 1'b1 && k < budget);
    check("start_seen", {31'b0, add_start}, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_acc"}, {16'b0, Acc}, 32'd0);
    check({tag, "_add_a"}, {16'b0, add_a}, 32'd0);
    check({tag, "_add_b"}, {16'b0, add_b}, 32'd0);
    check({tag, "_count"}, {24'b0, acc_count}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_ovf"}, {31'b0, ovf}, 32'd0);
    check({tag, "_err"}, {31'b0, err}, 32'd0);
    check({tag, "_start"}, {31'b0, add_start}, 32'd0);
  endtask

  initial begin
    int starts_before;
    int k;
    int sw;
    repeat (3) @(negedge Clk);
    check_all_zero("reset");
    Reset_Clear = 1'b0;

    // Single press of 1.
    model_press(1);
    press(10'h001, 1);
    wait_idle(100);
    check("t1_starts", n_starts, 32'd1);
    check("t1_busy", {31'b0, busy}, 32'd0);
    check("t1_acc", {16'b0, Acc}, 32'h0001);

    // Four presses of 0x1FF with gaps and a longer button hold.
    repeat (4) begin
      model_press(10'h1FF);
      press(10'h1FF, 2);
      wait_idle(100);
      repeat (3) @(negedge Clk);
    end
    check("t2_acc", {16'b0, Acc}, 32'h07FD);
    check("t2_count", {24'b0, acc_count}, 32'd5);
    check("t2_ovf", {31'b0, ovf}, 32'd0);

    // Three presses during one long WAIT: one queued, two dropped.
    adder_lat = 7;
    model_press(3);
    press(10'd3, 1);
    wait_start(20);
    for (int i = 0; i < 3; i++) begin
      model_press(3);
      Run_Accumulate = 1'b1;
      @(negedge Clk);
      Run_Accumulate = 1'b0;
      @(negedge Clk);
    end
    wait_idle(200);
    adder_lat = 3;
    check("t3_starts", n_starts, 32'd7);
    check("t3_count", {24'b0, acc_count}, 32'd7);
    check("t3_acc", {16'b0, Acc}, 32'h0803);

    // Timeout with the adder silent.
    adder_en = 1'b0;
    starts_before = n_starts;
    press(10'd5, 1);
    k = 0;
    while (busy !== 1'b1 && k < 20) begin
      @(negedge Clk);
      k++;
    end
    k = 0;
    while (busy === 1'b1 && k < 50) begin
      k++;
      @(negedge Clk);
    end
    check("to_busy_cycles", k, 32'd9);
    check("to_err", {31'b0, err}, 32'd1);
    check("to_acc", {16'b0, Acc}, m_acc);
    check("to_count", {24'b0, acc_count}, m_cnt);
    check("to_starts", n_starts, starts_before + 1);
    adder_en = 1'b1;
    repeat (3) @(negedge Clk);

    // Fill the accumulator to all-ones, then wrap it.
    while (m_acc != MASK) begin
      sw = ((MASK - m_acc) >= 'h3FF) ? 'h3FF : (MASK - m_acc);
      model_press(sw);
      press(sw[SWW-1:0], 1);
      wait_idle(100);
    end
    check("pre_ovf_acc", {16'b0, Acc}, 32'hFFFF);
    check("pre_ovf_flag", {31'b0, ovf}, 32'd0);
    model_press(1);
    press(10'd1, 1);
    wait_idle(100);
    check("wrap_acc", {16'b0, Acc}, 32'd0);
    check("wrap_ovf", {31'b0, ovf}, 32'd1);
    model_press(7);
    press(10'd7, 1);
    wait_idle(100);
    check("ovf_sticky", {31'b0, ovf}, 32'd1);
    check("err_sticky", {31'b0, err}, 32'd1);

    // Randomized presses, sometimes a second one queued behind an add in flight.
    repeat (20) begin
      sw = $urandom_range(0, 1023);
      model_press(sw);
      press(sw[SWW-1:0], $urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) begin
        repeat (2) @(negedge Clk);
        sw = $urandom_range(0, 1023);
        model_press(sw);
        press(sw[SWW-1:0], 1);
      end
      wait_idle(100);
      repeat ($urandom_range(0, 4)) @(negedge Clk);
    end

    // Asynchronous reset in the middle of WAIT; the late done must be ignored.
    model_press('h55);
    press(10'h055, 1);
    wait_start(20);
    @(negedge Clk);
    Reset_Clear = 1'b1;
    #1;
    check_all_zero("midwait");
    sb.delete();
    m_acc = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
    @(negedge Clk);
    Reset_Clear = 1'b0;
    repeat (5) @(negedge Clk);
    check("late_done_acc", {16'b0, Acc}, 32'd0);
    check("late_done_count", {24'b0, acc_count}, 32'd0);
    check("late_done_busy", {31'b0, busy}, 32'd0);
    model_press('h2A);
    press(10'h02A, 1);
    wait_idle(100);
    check("post_reset_acc", {16'b0, Acc}, 32'h002A);
    check("post_reset_count", {24'b0, acc_count}, 32'd1);

    check("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
